fetch_sequencer: RTL

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer_pkg.sv | 21 ++
 rtl/fetch_sequencer_pc_incr.sv | 13 +
 rtl/fetch_sequencer.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer.
//   state_t        : sequencer FSM states
//   PC_W_DEFAULT   : default program-counter width
//   DEPTH_DEFAULT  : default instruction-store depth (2**PC_W_DEFAULT)
//   RUN_START_PC   : pc loaded when execution (re)starts; the store then
//                    presents the word at address 0
package fetch_sequencer_pkg;

  localparam int PC_W_DEFAULT  = 4;
  localparam int DEPTH_DEFAULT = 16;
  localparam int RUN_START_PC  = 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    RUN   = 3'd2,
    FLUSH = 3'd3,
    HALT  = 3'd4
  } state_t;

endpackage

// File: rtl/fetch_sequencer_pc_incr.sv
// Modulo-DEPTH incrementer for program-counter values.
//   value          : input address
//   value_plus_one : value + 1, wrapping naturally at 2**PC_W
module fetch_sequencer_pc_incr #(
  parameter int PC_W = 4
) (
  input  logic [PC_W-1:0] value,
  output logic [PC_W-1:0] value_plus_one
);

  assign value_plus_one = value + PC_W'(1);

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: loads a program into the instruction store,
// then steps the pc through it with stall, jump (one-cycle flush) and halt.
//   clk          : clock, rising edge
//   reset        : asynchronous active-low reset
//   load_start   : begin a load session (IDLE only)
//   instr_valid  : one instruction word offered this cycle (LOAD)
//   load_done    : end the load session
//   run_start    : start execution from address 0 (IDLE, HALT)
//   stall        : hold pc in RUN
//   jump_req     : taken jump in RUN
//   jump_target  : jump destination address
//   halt_req     : stop execution
//   pc           : registered pc; the store presents the word at pc-1
//   write_enable : store write strobe (LOAD and instr_valid)
//   flush_jump   : registered flush strobe, high for the FLUSH cycle
//   fetch_valid  : store output word is valid this cycle
//   load_count   : words written in the current/last load session
//   halted       : high in HALT
module fetch_sequencer #(
  parameter int PC_W  = fetch_sequencer_pkg::PC_W_DEFAULT,
  parameter int DEPTH = fetch_sequencer_pkg::DEPTH_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load_start,
  input  logic            instr_valid,
  input  logic            load_done,
  input  logic            run_start,
  input  logic            stall,
  input  logic            jump_req,
  input  logic [PC_W-1:0] jump_target,
  input  logic            halt_req,
  output logic [PC_W-1:0] pc,
  output logic            write_enable,
  output logic            flush_jump,
  output logic            fetch_valid,
  output logic [PC_W:0]   load_count,
  output logic            halted
);

  import fetch_sequencer_pkg::*;

  localparam logic [PC_W-1:0] START_PC  = PC_W'(RUN_START_PC);
  localparam logic [PC_W:0]   COUNT_MAX = (PC_W+1)'(DEPTH);

  state_t          state_reg;
  logic [PC_W-1:0] pc_reg;
  logic [PC_W-1:0] target_reg;
  logic [PC_W:0]   load_count_reg;
  logic            flush_jump_reg;
  logic            halted_reg;

  logic [PC_W-1:0] pc_plus_one;
  logic [PC_W-1:0] target_plus_one;
  logic [PC_W:0]   count_next;

  fetch_sequencer_pc_incr #(.PC_W(PC_W)) u_pc_incr (
    .value          (pc_reg),
    .value_plus_one (pc_plus_one)
  );

  fetch_sequencer_pc_incr #(.PC_W(PC_W)) u_target_incr (
    .value          (target_reg),
    .value_plus_one (target_plus_one)
  );

  assign count_next = load_count_reg + (PC_W+1)'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= IDLE;
      pc_reg         <= '0;
      target_reg     <= '0;
      load_count_reg <= '0;
      flush_jump_reg <= 1'b0;
      halted_reg     <= 1'b0;
    end else begin
      flush_jump_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (load_start) begin
            state_reg      <= LOAD;
            load_count_reg <= '0;
          end else if (run_start) begin
            state_reg <= RUN;
            pc_reg    <= START_PC;
          end
        end

        LOAD: begin
          // The session closes on the word that fills the store, so the
          // count can never step past DEPTH.
          if (instr_valid && load_count_reg != COUNT_MAX) begin
            load_count_reg <= count_next;
            if (count_next == COUNT_MAX)
              state_reg <= IDLE;
          end
          if (load_done)
            state_reg <= IDLE;
        end

        RUN: begin
          if (halt_req) begin
            state_reg  <= HALT;
            halted_reg <= 1'b1;
          end else if (jump_req) begin
            state_reg      <= FLUSH;
            target_reg     <= jump_target;
            flush_jump_reg <= 1'b1;
          end else if (!stall) begin
            pc_reg <= pc_plus_one;
          end
        end

        // pc still shows the pre-jump value here; the store discards its
        // in-flight word and the new stream starts at the jump target.
        FLUSH: begin
          state_reg <= RUN;
          pc_reg    <= target_plus_one;
        end

        HALT: begin
          if (run_start) begin
            state_reg  <= RUN;
            pc_reg     <= START_PC;
            halted_reg <= 1'b0;
          end
        end

        default: begin
          state_reg  <= IDLE;
          halted_reg <= 1'b0;
        end
      endcase
    end
  end

  assign pc           = pc_reg;
  assign flush_jump   = flush_jump_reg;
  assign load_count   = load_count_reg;
  assign halted       = halted_reg;
  assign write_enable = (state_reg == LOAD) && instr_valid;
  assign fetch_valid  = (state_reg == RUN) && !stall && !halt_req;

endmodule
